display_ctrl: RTL

- Controller that sequences the 4-digit seven-segment mux for the game display.
- Generates the periodic scan_en strobe and converts two binary sources into BCD digit nibbles: score on d3/d2, shot-clock timer on d1/d0.
- Shares one sequential binary-to-BCD converter between the two sources through a round-robin scheduler.
- Applies leading-zero blanking, clamping and game-over blinking.
- Sits between game logic and sevenseg_mux.

---
 rtl/display_pkg.sv | 24 ++
 rtl/bin2bcd_seq.sv | 55 +++++
 rtl/display_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the game display controller.
// Digit pairs use BLANK to switch a seven-segment digit off.
package display_pkg;

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [6:0] MAX_VAL = 7'd99;

  typedef enum logic {
    SRC_TIMER = 1'b0,
    SRC_SCORE = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Two BCD digits only reach 99, so larger inputs saturate there.
  function automatic logic [6:0] clamp(input logic [6:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 7-bit binary to two BCD nibbles.
// Performs one add-3/shift step per clock; done pulses 8 clk after start is taken.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // {tens, ones, remaining binary bits}
  logic [14:0] sr;
  logic [2:0]  cnt;

  function automatic logic [14:0] dd_step(input logic [14:0] s);
    logic [14:0] a;
    a = s;
    if (a[10:7] >= 4'd5)  a[10:7]  = a[10:7]  + 4'd3;
    if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
    return {a[13:0], 1'b0};
  endfunction

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          sr   <= {8'd0, bin};
          cnt  <= '0;
          busy <= 1'b1;
        end
      end else if (cnt == 3'd7) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        sr  <= dd_step(sr);
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign tens = sr[14:11];
  assign ones = sr[10:7];

endmodule

// File: rtl/display_ctrl.sv
// Seven-segment scan controller: scan strobe, shared BCD conversion of score
// and shot clock, leading-zero blanking, clamping and game-over blinking.
module display_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] timer_val,
  input  logic [6:0] score_val,
  input  logic       game_over,
  output logic       scan_en,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       busy
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_CONV   = CONV;
  localparam logic [1:0] ST_COMMIT = COMMIT;

  logic [CW-1:0] pre_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic [1:0] state;
  src_e       sel, last_served, pick;
  logic [6:0] t_clamp, s_clamp, snap_t, snap_s, conv_bin;
  logic       req_t, req_s, start;
  logic       conv_busy, conv_done;
  logic [3:0] conv_tens, conv_ones;
  logic [3:0] dig3, dig2, dig1, dig0;

  // Scan strobe is registered: it rises on the edge where the count wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      scan_en <= 1'b0;
    end else if (pre_cnt == CW'(SCAN_DIV - 1)) begin
      pre_cnt <= '0;
      scan_en <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + CW'(1);
      scan_en <= 1'b0;
    end
  end

  assign t_clamp = clamp(timer_val);
  assign s_clamp = clamp(score_val);
  assign req_t   = (t_clamp != snap_t);
  assign req_s   = (s_clamp != snap_s);

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pick = SRC_TIMER;
    if (req_t && req_s)
      pick = (last_served == SRC_TIMER) ? SRC_SCORE : SRC_TIMER;
    else if (req_s)
      pick = SRC_SCORE;
  end

  assign start    = (state == ST_IDLE) && (req_t || req_s) && !conv_busy;
  assign conv_bin = (pick == SRC_TIMER) ? t_clamp : s_clamp;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Snapshots reset to an out-of-range value so both sources convert after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= SRC_TIMER;
      last_served <= SRC_SCORE;
      snap_t      <= 7'h7F;
      snap_s      <= 7'h7F;
      busy        <= 1'b0;
      dig3        <= BLANK;
      dig2        <= BLANK;
      dig1        <= BLANK;
      dig0        <= BLANK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel <= pick;
            if (pick == SRC_TIMER) snap_t <= t_clamp;
            else                   snap_s <= s_clamp;
            busy  <= 1'b1;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (conv_done) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (sel == SRC_TIMER) begin
            dig1 <= (conv_tens == 4'd0) ? BLANK : conv_tens;
            dig0 <= conv_ones;
          end else begin
            dig3 <= (conv_tens == 4'd0) ? BLANK : conv_tens;
            dig2 <= conv_ones;
          end
          last_served <= sel;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Blink phase only advances while game_over; releasing it restores digits at once.
  always_ff @(posedge clk) begin
    if (rst || !game_over) begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (scan_en) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign d3 = blink_on ? dig3 : BLANK;
  assign d2 = blink_on ? dig2 : BLANK;
  assign d1 = blink_on ? dig1 : BLANK;
  assign d0 = blink_on ? dig0 : BLANK;

endmodule
